matrix_alu_initiator: RTL and testbench

- Bus-master sequencer that drives one complete matrix operation on the Matrix ALU register interface on behalf of the execution engine.
- On a Start pulse it captures opcode and both source matrices, then runs the bus sequence: write Source1, write Source2, write command to StatusIn, poll StatusOut, read Result.
- Hands the 256-bit result back upstream with a Done pulse.
- Sits between execution-engine control and the shared address/nRead/nWrite/data bus.

---
 rtl/matrix_alu_initiator.sv | 141 ++++++++++++++
 tb/tb_matrix_alu_initiator.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_alu_initiator.sv
// Matrix ALU bus initiator: runs one full matrix op on the ALU register bus.
// Ports: Clk/Reset, Start/OpCode/Src1In/Src2In request, Busy/Done/Err/ResultOut, ALU bus.
`timescale 1ns/1ps
module matrix_alu_initiator #(
  parameter logic [3:0]  ALU_UNIT     = 4'h1,
  parameter int unsigned POLL_TIMEOUT = 255
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [7:0]   OpCode,
  input  logic [255:0] Src1In,
  input  logic [255:0] Src2In,
  output logic         Busy,
  output logic         Done,
  output logic         Err,
  output logic [255:0] ResultOut,
  output logic [15:0]  address,
  output logic         nRead,
  output logic         nWrite,
  output logic [255:0] ExeDataOut,
  input  logic [255:0] MatrixDataOut
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_SRC1, S_WR_SRC2, S_WR_CMD,
    S_POLL, S_RD_RES, S_DONE, S_ERR
  } state_t;

  localparam logic [7:0] LP_TIMEOUT = 8'(POLL_TIMEOUT);

  state_t       r_state;
  logic [7:0]   r_op;
  logic [7:0]   r_poll_cnt;
  logic [255:0] r_src1;
  logic [255:0] r_src2;
  logic [255:0] r_result;
  logic [7:0]   w_poll_nxt;
  logic [7:0]   w_off;
  logic         w_bus;

  // saturating so a huge timeout can never wrap back to zero
  assign w_poll_nxt = (r_poll_cnt == 8'hFF) ? 8'hFF : r_poll_cnt + 8'd1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_poll_cnt <= '0;
      r_src1     <= '0;
      r_src2     <= '0;
      r_result   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            if (OpCode <= 8'd7) begin
              r_op    <= OpCode;
              r_src1  <= Src1In;
              r_src2  <= Src2In;
              r_state <= S_WR_SRC1;
            end else begin
              r_state <= S_ERR;
            end
          end
        end
        S_WR_SRC1:
          r_state <= (r_op == 8'd5) ? S_WR_CMD : S_WR_SRC2;
        S_WR_SRC2:
          r_state <= S_WR_CMD;
        S_WR_CMD: begin
          r_poll_cnt <= '0;
          r_state    <= S_POLL;
        end
        S_POLL: begin
          if (MatrixDataOut[0]) begin
            r_state <= S_RD_RES;
          end else begin
            r_poll_cnt <= w_poll_nxt;
            if (w_poll_nxt >= LP_TIMEOUT)
              r_state <= S_ERR;
          end
        end
        S_RD_RES: begin
          r_result <= MatrixDataOut;
          r_state  <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // bus strobes depend on the state register only
  always_comb begin
    w_off      = 8'h00;
    w_bus      = 1'b0;
    nRead      = 1'b1;
    nWrite     = 1'b1;
    ExeDataOut = '0;
    case (r_state)
      S_WR_SRC1: begin
        w_off      = 8'h02;
        w_bus      = 1'b1;
        nWrite     = 1'b0;
        ExeDataOut = r_src1;
      end
      S_WR_SRC2: begin
        w_off      = 8'h03;
        w_bus      = 1'b1;
        nWrite     = 1'b0;
        ExeDataOut = r_src2;
      end
      S_WR_CMD: begin
        w_off      = 8'h00;
        w_bus      = 1'b1;
        nWrite     = 1'b0;
        ExeDataOut = {248'b0, r_op};
      end
      S_POLL: begin
        w_off = 8'h01;
        w_bus = 1'b1;
        nRead = 1'b0;
      end
      S_RD_RES: begin
        w_off = 8'h04;
        w_bus = 1'b1;
        nRead = 1'b0;
      end
      default: ;
    endcase
  end

  assign address   = w_bus ? {ALU_UNIT, 4'h0, w_off} : 16'h0000;
  assign Busy      = (r_state != S_IDLE);
  assign Done      = (r_state == S_DONE);
  assign Err       = (r_state == S_ERR);
  assign ResultOut = r_result;

endmodule

// File: tb/tb_matrix_alu_initiator.sv
// Directed bench for matrix_alu_initiator with a small ALU register model.
// Checks bus sequence, latency, polling, timeout, bad opcode and reset.
`timescale 1ns/1ps
module tb_matrix_alu_initiator;

  logic         Clk = 1'b0;
  logic         Reset, Start;
  logic [7:0]   OpCode;
  logic [255:0] Src1In, Src2In;
  logic         Busy, Done, Err, nRead, nWrite;
  logic [255:0] ResultOut, ExeDataOut, MatrixDataOut;
  logic [15:0]  address;

  int n_vec = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  matrix_alu_initiator #(.ALU_UNIT(4'h1), .POLL_TIMEOUT(4)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .OpCode(OpCode),
    .Src1In(Src1In), .Src2In(Src2In), .Busy(Busy), .Done(Done),
    .Err(Err), .ResultOut(ResultOut), .address(address),
    .nRead(nRead), .nWrite(nWrite), .ExeDataOut(ExeDataOut),
    .MatrixDataOut(MatrixDataOut)
  );

  // ALU register model
  logic [255:0] m_s1, m_s2, m_res;
  int pwait = 0;
  int m_seen = 0;
  logic m_rdy;

  function automatic logic [255:0] alu_f(
    input logic [7:0] op, input logic [255:0] a, input logic [255:0] b);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (op == 8'd3)
          r[(i*4+j)*16 +: 16] = a[(i*4+j)*16 +: 16] + b[(i*4+j)*16 +: 16];
        else if (op == 8'd5)
          r[(j*4+i)*16 +: 16] = a[(i*4+j)*16 +: 16];
    return r;
  endfunction

  assign m_rdy = (m_seen >= pwait);
  assign MatrixDataOut = (address[7:0] == 8'h01) ? {255'b0, m_rdy} :
                         (address[7:0] == 8'h04) ? m_res : '0;

  always @(posedge Clk) begin
    if (!Reset) begin
      if (!nWrite) begin
        case (address[7:0])
          8'h02: m_s1 <= ExeDataOut;
          8'h03: m_s2 <= ExeDataOut;
          8'h00: begin
            m_res  <= alu_f(ExeDataOut[7:0], m_s1, m_s2);
            m_seen <= 0;
          end
          default: ;
        endcase
      end
      if (!nRead && address[7:0] == 8'h01 && !m_rdy)
        m_seen <= m_seen + 1;
    end
  end

  // bus monitor
  logic [16:0]  blog[$];
  logic [255:0] cmd_data, s1_data;

  always @(negedge Clk) begin
    if (!Reset) begin
      if (!nWrite) begin
        blog.push_back({1'b1, address});
        if (address[7:0] == 8'h00) cmd_data = ExeDataOut;
        if (address[7:0] == 8'h02) s1_data = ExeDataOut;
      end
      if (!nRead) blog.push_back({1'b0, address});
    end
  end

  function automatic int cnt_log(input logic [16:0] e);
    int n;
    n = 0;
    foreach (blog[k]) if (blog[k] == e) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [7:0] op, input logic [255:0] s1,
                        input logic [255:0] s2, output int dcyc,
                        output int ecyc, output int bcyc, output int ecnt);
    blog.delete();
    dcyc = 0; ecyc = 0; bcyc = 0; ecnt = 0;
    @(negedge Clk);
    Start = 1'b1; OpCode = op; Src1In = s1; Src2In = s2;
    @(posedge Clk);
    #1;
    // scramble inputs: the DUT must use its latched copies
    Start = 1'b0; OpCode = ~op; Src1In = ~s1; Src2In = ~s2;
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clk);
      if (Busy) bcyc++;
      if (Done && dcyc == 0) dcyc = c;
      if (Err) begin
        ecnt++;
        if (ecyc == 0) ecyc = c;
      end
    end
  endtask

  int d, e, b, ec, dseen;
  logic [255:0] s1, exp_t;

  initial begin
    Reset = 1'b1; Start = 1'b0; OpCode = '0;
    Src1In = '0; Src2In = '0;
    repeat (2) @(negedge Clk);
    chk("rst_ctl", {nRead, nWrite, Busy, Done, Err}, 5'b11000);
    chk("rst_addr", address, 16'h0000);
    chk("rst_data", ExeDataOut, '0);
    chk("rst_res", ResultOut, '0);
    Reset = 1'b0;

    // Madd 2+3
    pwait = 0;
    run_op(8'd3, {16{16'h0002}}, {16{16'h0003}}, d, e, b, ec);
    chk("madd_done_cyc", d, 6);
    chk("madd_err", ec, 0);
    chk("madd_res", ResultOut, {16{16'h0005}});
    chk("madd_nlog", blog.size(), 5);
    chk("madd_bus0", blog[0], 17'h11002);
    chk("madd_bus1", blog[1], 17'h11003);
    chk("madd_bus2", blog[2], 17'h11000);
    chk("madd_bus3", blog[3], 17'h01001);
    chk("madd_bus4", blog[4], 17'h01004);
    chk("madd_cmd", cmd_data, 256'd3);
    chk("madd_src1", s1_data, {16{16'h0002}});
    chk("idle_busy", Busy, 1'b0);

    // Mtranspose
    s1 = '0;
    s1[0 +: 16] = 16'd1;
    s1[(0*4+1)*16 +: 16] = 16'd7;
    s1[(2*4+3)*16 +: 16] = 16'd9;
    exp_t = '0;
    exp_t[0 +: 16] = 16'd1;
    exp_t[(1*4+0)*16 +: 16] = 16'd7;
    exp_t[(3*4+2)*16 +: 16] = 16'd9;
    run_op(8'd5, s1, {16{16'hAAAA}}, d, e, b, ec);
    chk("tr_done_cyc", d, 5);
    chk("tr_nlog", blog.size(), 4);
    chk("tr_no_src2", cnt_log(17'h11003), 0);
    chk("tr_cmd", cmd_data, 256'd5);
    chk("tr_res", ResultOut, exp_t);

    // three not-ready polls
    pwait = 3;
    run_op(8'd3, {16{16'h0001}}, {16{16'h0010}}, d, e, b, ec);
    chk("poll3_done_cyc", d, 9);
    chk("poll3_polls", cnt_log(17'h01001), 4);
    chk("poll3_res", ResultOut, {16{16'h0011}});

    // timeout after 4 polls
    pwait = 100;
    run_op(8'd4, {16{16'h0009}}, {16{16'h0001}}, d, e, b, ec);
    chk("to_err_cyc", e, 8);
    chk("to_err_cnt", ec, 1);
    chk("to_done", d, 0);
    chk("to_polls", cnt_log(17'h01001), 4);
    chk("to_no_rd", cnt_log(17'h01004), 0);
    chk("to_res_hold", ResultOut, {16{16'h0011}});

    // invalid opcode
    pwait = 0;
    run_op(8'h08, {16{16'h0002}}, {16{16'h0003}}, d, e, b, ec);
    chk("bad_err_cyc", e, 1);
    chk("bad_err_cnt", ec, 1);
    chk("bad_busy", b, 1);
    chk("bad_nlog", blog.size(), 0);
    chk("bad_done", d, 0);

    // reset during the second poll
    pwait = 100;
    @(negedge Clk);
    Start = 1'b1; OpCode = 8'd3;
    Src1In = {16{16'h0002}}; Src2In = {16{16'h0003}};
    @(posedge Clk);
    #1 Start = 1'b0;
    repeat (5) @(negedge Clk);
    chk("mid_poll2", {address, nRead}, {16'h1001, 1'b0});
    Reset = 1'b1;
    #1;
    chk("mid_rst_bus", {address, nRead, nWrite}, {16'h0000, 2'b11});
    chk("mid_rst_res", ResultOut, '0);
    chk("mid_rst_busy", Busy, 1'b0);
    dseen = 0;
    repeat (3) begin
      @(negedge Clk);
      if (Done || Err) dseen++;
    end
    Reset = 1'b0;
    pwait = 0;
    repeat (2) begin
      @(negedge Clk);
      if (Done || Err) dseen++;
    end
    chk("mid_no_pulse", dseen, 0);
    run_op(8'd3, {16{16'h0002}}, {16{16'h0003}}, d, e, b, ec);
    chk("post_done_cyc", d, 6);
    chk("post_res", ResultOut, {16{16'h0005}});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
